// File: rtl/neuron_pkg.sv
// Shared sizes and FSM state type for the neuron weight sequencer.
// Q8.8 operands, 28-term dot product, 36-bit accumulation.
package neuron_pkg;

  localparam int N_WEIGHTS = 28;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 16;
  localparam int ACC_W     = 36;
  localparam int PROD_W    = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_MAC,
    S_FINISH
  } state_t;

endpackage

// File: rtl/neuron_weight_seq_if.sv
// Handshake, weight-load, BRAM and result bundle of the sequencer.
// master = environment side, slave = sequencer side.
interface neuron_weight_seq_if;
  import neuron_pkg::*;

  logic              START;
  logic              PIX_VALID;
  logic [DATA_W-1:0] PIX_DATA;
  logic              PIX_READY;
  logic              LD_VALID;
  logic [ADDR_W-1:0] LD_ADDR;
  logic [DATA_W-1:0] LD_DATA;
  logic              LD_READY;
  logic [ADDR_W-1:0] BRAM_ADDR;
  logic [DATA_W-1:0] BRAM_DI;
  logic              BRAM_EN;
  logic              BRAM_WE;
  logic [DATA_W-1:0] BRAM_DO;
  logic              BUSY;
  logic              DONE;
  logic [ACC_W-1:0]  ACC_OUT;
  logic              LD_ERR;

  modport master (
    output START, PIX_VALID, PIX_DATA,
    output LD_VALID, LD_ADDR, LD_DATA,
    output BRAM_DO,
    input  PIX_READY, LD_READY,
    input  BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE,
    input  BUSY, DONE, ACC_OUT, LD_ERR
  );

  modport slave (
    input  START, PIX_VALID, PIX_DATA,
    input  LD_VALID, LD_ADDR, LD_DATA,
    input  BRAM_DO,
    output PIX_READY, LD_READY,
    output BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE,
    output BUSY, DONE, ACC_OUT, LD_ERR
  );

endinterface

// File: rtl/neuron_mac_dp.sv
// Signed Q8.8 multiply-accumulate register.
// Full 32-bit product, sign-extended into a 36-bit sum.
module neuron_mac_dp
  import neuron_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         prod_x;

  assign prod = PROD_W'($signed(a)) * PROD_W'($signed(b));
  assign prod_x = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Clear wins over accumulate; otherwise add one term per enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end

endmodule

// File: rtl/neuron_weight_seq.sv
// Weight-load and dot-product sequencer over an external weight BRAM.
// Each term: READ issues the BRAM read, MAC consumes one pixel.
module neuron_weight_seq
  import neuron_pkg::*;
(
  input logic                CLK,
  input logic                RST_N,
  neuron_weight_seq_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] idx;
  logic              pend;
  logic              ld_err;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_out_q;
  logic              ld_bad;
  logic              go;
  logic              coll;
  logic              hs;
  logic              last;
  logic              mac_clr;

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(N_WEIGHTS - 1);

  assign ld_bad  = bus.LD_ADDR > LAST_IDX;
  assign go      = (state == S_IDLE) && bus.START
                   && !bus.LD_VALID;
  assign coll    = (state == S_IDLE) && bus.START
                   && bus.LD_VALID;
  assign hs      = (state == S_MAC) && bus.PIX_VALID;
  assign last    = idx == LAST_IDX;
  // A start that collided with a load clears the sum in READ.
  assign mac_clr = go || ((state == S_READ) && pend);

  assign bus.ACC_OUT = (state == S_FINISH) ? acc : acc_out_q;
  assign bus.LD_ERR  = ld_err;

  neuron_mac_dp u_mac (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (mac_clr),
    .en    (hs),
    .a     (bus.PIX_DATA),
    .b     (bus.BRAM_DO),
    .acc   (acc)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, handshakes and BRAM port drive.
  always_comb begin
    state_nx      = state;
    bus.LD_READY  = 1'b0;
    bus.PIX_READY = 1'b0;
    bus.BRAM_EN   = 1'b0;
    bus.BRAM_WE   = 1'b0;
    bus.BRAM_ADDR = '0;
    bus.BRAM_DI   = '0;
    bus.BUSY      = 1'b0;
    bus.DONE      = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.LD_READY = 1'b1;
        if (bus.LD_VALID && !ld_bad) begin
          bus.BRAM_EN   = 1'b1;
          bus.BRAM_WE   = 1'b1;
          bus.BRAM_ADDR = bus.LD_ADDR;
          bus.BRAM_DI   = bus.LD_DATA;
        end
        if (bus.START) begin
          state_nx = S_READ;
        end
      end
      S_READ: begin
        bus.BUSY      = 1'b1;
        bus.BRAM_EN   = 1'b1;
        bus.BRAM_ADDR = idx;
        state_nx      = S_MAC;
      end
      S_MAC: begin
        bus.BUSY      = 1'b1;
        bus.PIX_READY = 1'b1;
        if (bus.PIX_VALID) begin
          state_nx = last ? S_FINISH : S_READ;
        end
      end
      S_FINISH: begin
        bus.BUSY = 1'b1;
        bus.DONE = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Term index, pending start, load error and result hold.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx       <= '0;
      pend      <= 1'b0;
      ld_err    <= 1'b0;
      acc_out_q <= '0;
    end else begin
      if (go || coll) begin
        idx <= '0;
      end else if (hs && !last) begin
        idx <= idx + 1'b1;
      end
      if (coll) begin
        pend <= 1'b1;
      end else if (state == S_READ) begin
        pend <= 1'b0;
      end
      if (coll) begin
        ld_err <= ld_bad;
      end else if (go) begin
        ld_err <= 1'b0;
      end else if (bus.LD_VALID && bus.LD_READY && ld_bad) begin
        ld_err <= 1'b1;
      end
      if (state == S_FINISH) begin
        acc_out_q <= acc;
      end
    end
  end

endmodule

// File: tb/tb_neuron_weight_seq.sv
// Directed bench for neuron_weight_seq with a BRAM model and
// a transaction-level dot-product / timing reference.
module tb_neuron_weight_seq;
  import neuron_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  neuron_weight_seq_if ifc();

  neuron_weight_seq dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (ifc.slave)
  );

  logic [15:0] mem [0:31];

  // Weight BRAM: registered on the falling edge.
  always @(negedge clk) begin
    if (ifc.BRAM_EN) begin
      if (ifc.BRAM_WE) mem[ifc.BRAM_ADDR] <= ifc.BRAM_DI;
      else ifc.BRAM_DO <= mem[ifc.BRAM_ADDR];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int hs_cnt = 0;
  always @(posedge clk)
    if (rst_n && ifc.PIX_VALID && ifc.PIX_READY)
      hs_cnt <= hs_cnt + 1;

  logic [15:0] wt  [N_WEIGHTS];
  logic [15:0] pix [N_WEIGHTS];
  int          start_cyc = -1;
  int          done_cyc = -1;
  logic [35:0] res_old = '0;
  logic [35:0] res_new = '0;
  logic        err_m = 1'b0;
  int          vecs = 0;
  int          miss = 0;

  function automatic logic [35:0] dot();
    longint s;
    s = 0;
    for (int i = 0; i < N_WEIGHTS; i++)
      s += longint'($signed(wt[i])) * longint'($signed(pix[i]));
    return s[35:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    logic [35:0] e_acc;
    if (rst_n) begin
      e_acc = (done_cyc >= 0 && cyc >= done_cyc) ? res_new : res_old;
      chk("done", 64'(ifc.DONE), 64'(cyc == done_cyc));
      chk("acc_out", 64'(ifc.ACC_OUT), 64'(e_acc));
      chk("busy", 64'(ifc.BUSY),
          64'(start_cyc >= 0 && cyc > start_cyc && cyc <= done_cyc));
      chk("ld_err", 64'(ifc.LD_ERR), 64'(err_m));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    bit ok;
    ok = a < N_WEIGHTS;
    ifc.LD_VALID = 1'b1;
    ifc.LD_ADDR  = 5'(a);
    ifc.LD_DATA  = d;
    if (ok) wt[a] = d;
    #1;
    chk("ld_ready", 64'(ifc.LD_READY), 64'(1));
    chk("ld_en", 64'(ifc.BRAM_EN), 64'(ok));
    chk("ld_we", 64'(ifc.BRAM_WE), 64'(ok));
    chk("ld_addr", 64'(ifc.BRAM_ADDR), 64'(ok ? a : 0));
    chk("ld_di", 64'(ifc.BRAM_DI), 64'(ok ? d : 16'h0));
    tick();
    ifc.LD_VALID = 1'b0;
    if (!ok) err_m = 1'b1;
  endtask

  task automatic begin_run(input int stall_len, input bit collide,
                           input int caddr, input logic [15:0] cdata);
    if (done_cyc >= 0) res_old = res_new;
    ifc.START = 1'b1;
    if (collide) begin
      ifc.LD_VALID = 1'b1;
      ifc.LD_ADDR  = 5'(caddr);
      ifc.LD_DATA  = cdata;
      wt[caddr]    = cdata;
    end
    res_new     = dot();
    start_cyc   = cyc;
    done_cyc    = cyc + 57 + stall_len;
    ifc.PIX_VALID = 1'b1;
    ifc.PIX_DATA  = pix[0];
    if (collide) begin
      #1;
      chk("coll_en", 64'(ifc.BRAM_EN), 64'(1));
      chk("coll_we", 64'(ifc.BRAM_WE), 64'(1));
      chk("coll_addr", 64'(ifc.BRAM_ADDR), 64'(caddr));
      chk("coll_di", 64'(ifc.BRAM_DI), 64'(cdata));
      chk("idle_pix_rdy", 64'(ifc.PIX_READY), 64'(0));
    end
    tick();
    ifc.LD_VALID = 1'b0;
    err_m = 1'b0;
    chk("read_en", 64'(ifc.BRAM_EN), 64'(1));
    chk("read_we", 64'(ifc.BRAM_WE), 64'(0));
    chk("read_addr", 64'(ifc.BRAM_ADDR), 64'(0));
    chk("busy_ld_rdy", 64'(ifc.LD_READY), 64'(0));
  endtask

  task automatic run(input int stall_len, input bit collide,
                     input int caddr, input logic [15:0] cdata,
                     input bit has_lit, input logic [35:0] lit);
    int base;
    int term;
    int stalled;
    bit seen;
    base = hs_cnt;
    stalled = 0;
    seen = 1'b0;
    begin_run(stall_len, collide, caddr, cdata);
    for (int n = 0; n < 300 && !seen; n++) begin
      tick();
      ifc.START = 1'b0;
      term = hs_cnt - base;
      ifc.PIX_DATA = pix[term < N_WEIGHTS ? term : N_WEIGHTS - 1];
      if (term == 5 && ifc.PIX_READY && stalled < stall_len) begin
        ifc.PIX_VALID = 1'b0;
        stalled++;
        if (stalled == stall_len) begin
          #1;
          chk("stall_en", 64'(ifc.BRAM_EN), 64'(0));
          chk("stall_rdy", 64'(ifc.PIX_READY), 64'(1));
        end
      end else begin
        ifc.PIX_VALID = 1'b1;
      end
      if (ifc.DONE) begin
        seen = 1'b1;
        chk("latency", 64'(cyc - start_cyc), 64'(57 + stall_len));
        if (has_lit) chk("acc_lit", 64'(ifc.ACC_OUT), 64'(lit));
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
    tick();
    ifc.PIX_VALID = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", 64'(ifc.BUSY), 64'(0));
    chk("rst_done", 64'(ifc.DONE), 64'(0));
    chk("rst_acc", 64'(ifc.ACC_OUT), 64'(0));
    chk("rst_err", 64'(ifc.LD_ERR), 64'(0));
    chk("rst_ld_rdy", 64'(ifc.LD_READY), 64'(1));
    chk("rst_pix_rdy", 64'(ifc.PIX_READY), 64'(0));
    chk("rst_en", 64'(ifc.BRAM_EN), 64'(0));
    chk("rst_we", 64'(ifc.BRAM_WE), 64'(0));
    chk("rst_addr", 64'(ifc.BRAM_ADDR), 64'(0));
  endtask

  task automatic model_reset();
    start_cyc = -1;
    done_cyc  = -1;
    res_old   = '0;
    res_new   = '0;
    err_m     = 1'b0;
  endtask

  task automatic run_reset_at12();
    int base;
    bit hit;
    base = hs_cnt;
    hit = 1'b0;
    begin_run(0, 1'b0, 0, 16'h0);
    for (int n = 0; n < 100 && !hit; n++) begin
      tick();
      ifc.START = 1'b0;
      ifc.PIX_DATA = pix[0];
      if (hs_cnt - base == 12 && ifc.PIX_READY) hit = 1'b1;
    end
    chk("reach_idx12", 64'(hit), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 70; n++) tick();
    ifc.PIX_VALID = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.START = 1'b0;
    ifc.PIX_VALID = 1'b0;
    ifc.PIX_DATA = '0;
    ifc.LD_VALID = 1'b0;
    ifc.LD_ADDR = '0;
    ifc.LD_DATA = '0;
    tick();
    tick();
    chk_reset_outs();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < N_WEIGHTS; i++) pix[i] = 16'h0100;
    for (int i = 0; i < N_WEIGHTS; i++) load(i, 16'h0100);
    run(0, 1'b0, 0, 16'h0, 1'b1, 36'h001C0000);
    run(10, 1'b0, 0, 16'h0, 1'b1, 36'h001C0000);
    run(0, 1'b1, 3, 16'h0200, 1'b1, 36'h001D0000);

    for (int i = 0; i < N_WEIGHTS; i++) pix[i] = 16'h8000;
    for (int i = 0; i < N_WEIGHTS; i++) load(i, 16'h8000);
    run(0, 1'b0, 0, 16'h0, 1'b1, 36'h700000000);

    for (int i = 0; i < N_WEIGHTS; i++) begin
      pix[i] = 16'(25000 - i * 1789);
      load(i, 16'(i * 1237 - 17000));
    end
    run(3, 1'b0, 0, 16'h0, 1'b0, '0);

    load(30, 16'h1234);
    for (int n = 0; n < 5; n++) tick();
    run_reset_at12();

    load(31, 16'h4321);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_clr_err", 64'(ifc.LD_ERR), 64'(0));
    err_m = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
